// File: rtl/keyboard_uart_tx.sv
// keyboard_uart_tx: accepts keyboard characters over a ready/valid handshake,
// buffers them in a small circular FIFO and serializes each one as an
// asynchronous UART frame (start bit, 8 data bits LSB first, stop bit).
// Optional feature macro: KEYBOARD_UART_TX_PARITY_EN adds an even parity bit
// after the data bits (8E1, 11-bit frames); without it frames are 8N1.
module keyboard_uart_tx #(
    parameter int CLOCK_DIVISOR   = 234,
    parameter int FIFO_DEPTH_LOG2 = 4
) (
    input  logic       clk,
    input  logic       reset,
    output logic       character_ready,
    input  logic       character_valid,
    input  logic [7:0] character_byte,
    output logic       uart_tx,
    output logic       busy
);

    localparam int DEPTH   = 1 << FIFO_DEPTH_LOG2;
    localparam int TIMER_W = (CLOCK_DIVISOR > 1) ? $clog2(CLOCK_DIVISOR) : 1;
    localparam int CNT_W   = FIFO_DEPTH_LOG2 + 1;

    localparam logic [TIMER_W-1:0]         TIMER_ZERO = TIMER_W'(0);
    localparam logic [TIMER_W-1:0]         TIMER_ONE  = TIMER_W'(1);
    localparam logic [TIMER_W-1:0]         TIMER_LAST = TIMER_W'(CLOCK_DIVISOR - 1);
    localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ZERO   = FIFO_DEPTH_LOG2'(0);
    localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE    = FIFO_DEPTH_LOG2'(1);
    localparam logic [CNT_W-1:0]           COUNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0]           COUNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]           COUNT_FULL = CNT_W'(DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef KEYBOARD_UART_TX_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } tx_state_t;

    tx_state_t                  state_r;
    logic [TIMER_W-1:0]         timer_r;
    logic [2:0]                 bit_idx_r;
    logic [7:0]                 shift_r;
    logic [7:0]                 fifo_mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_r;
    logic [FIFO_DEPTH_LOG2-1:0] rd_ptr_r;
    logic [CNT_W-1:0]           count_r;
    logic                       push_s;
    logic                       pop_s;
    logic                       bit_end_s;
    logic                       fifo_empty_s;
    logic [7:0]                 head_s;
`ifdef KEYBOARD_UART_TX_PARITY_EN
    logic                       parity_r;
`endif

    // Ready is held low during reset so nothing is accepted while state is cleared.
    assign character_ready = (count_r != COUNT_FULL) && !reset;
    assign push_s          = character_valid && character_ready;
    assign fifo_empty_s    = (count_r == COUNT_ZERO);
    assign head_s          = fifo_mem[rd_ptr_r];
    assign bit_end_s       = (timer_r == TIMER_LAST);
    assign busy            = (count_r != COUNT_ZERO) || (state_r != ST_IDLE);

    // Pop the FIFO head when idle, or on the last stop-bit cycle for gapless frames.
    always_comb begin
        pop_s = 1'b0;
        if (fifo_empty_s) begin
            pop_s = 1'b0;
        end else if (state_r == ST_IDLE) begin
            pop_s = 1'b1;
        end else if ((state_r == ST_STOP) && bit_end_s) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
    end

    // FIFO storage write; contents need no reset because count gates reads.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem[wr_ptr_r] <= character_byte;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= COUNT_ZERO;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + COUNT_ONE;
                2'b01:   count_r <= count_r - COUNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

`ifdef KEYBOARD_UART_TX_PARITY_EN
    // Latch even parity of the byte as it leaves the FIFO; the shift register is empty by then.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            parity_r <= 1'b0;
        end else if (pop_s) begin
            parity_r <= ^head_s;
        end
    end
`endif

    // Transmitter FSM with a registered line driver that follows the state by one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            timer_r   <= TIMER_ZERO;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
            uart_tx   <= 1'b1;
        end else begin
            case (state_r)
                ST_START:  uart_tx <= 1'b0;
                ST_DATA:   uart_tx <= shift_r[0];
`ifdef KEYBOARD_UART_TX_PARITY_EN
                ST_PARITY: uart_tx <= parity_r;
`endif
                default:   uart_tx <= 1'b1;
            endcase

            case (state_r)
                ST_IDLE: begin
                    timer_r <= TIMER_ZERO;
                    if (pop_s) begin
                        shift_r <= head_s;
                        state_r <= ST_START;
                    end
                end
                ST_START: begin
                    if (bit_end_s) begin
                        timer_r   <= TIMER_ZERO;
                        bit_idx_r <= 3'd0;
                        state_r   <= ST_DATA;
                    end else begin
                        timer_r <= timer_r + TIMER_ONE;
                    end
                end
                ST_DATA: begin
                    if (bit_end_s) begin
                        timer_r   <= TIMER_ZERO;
                        shift_r   <= {1'b0, shift_r[7:1]};
                        bit_idx_r <= bit_idx_r + 3'd1;
                        if (bit_idx_r == 3'd7) begin
`ifdef KEYBOARD_UART_TX_PARITY_EN
                            state_r <= ST_PARITY;
`else
                            state_r <= ST_STOP;
`endif
                        end
                    end else begin
                        timer_r <= timer_r + TIMER_ONE;
                    end
                end
`ifdef KEYBOARD_UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (bit_end_s) begin
                        timer_r <= TIMER_ZERO;
                        state_r <= ST_STOP;
                    end else begin
                        timer_r <= timer_r + TIMER_ONE;
                    end
                end
`endif
                ST_STOP: begin
                    if (bit_end_s) begin
                        timer_r <= TIMER_ZERO;
                        if (pop_s) begin
                            shift_r <= head_s;
                            state_r <= ST_START;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end else begin
                        timer_r <= timer_r + TIMER_ONE;
                    end
                end
                default: begin
                    timer_r <= TIMER_ZERO;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keyboard_uart_tx.sv
// Directed testbench for keyboard_uart_tx with CLOCK_DIVISOR=4, FIFO_DEPTH_LOG2=2.
// Honours KEYBOARD_UART_TX_PARITY_EN for the expected frame layout.
module tb_keyboard_uart_tx;

    localparam int CD = 4;
`ifdef KEYBOARD_UART_TX_PARITY_EN
    localparam int FB = 11;
    // Line bits, bit 0 first on the wire: start, data LSB first, parity, stop.
    localparam logic [10:0] F41 = 11'h482;
    localparam logic [10:0] F43 = 11'h686;
    localparam logic [10:0] F55 = 11'h4AA;
    localparam logic [10:0] FAA = 11'h554;
`else
    localparam int FB = 10;
    localparam logic [10:0] F41 = 11'h282;
    localparam logic [10:0] F43 = 11'h286;
    localparam logic [10:0] F55 = 11'h2AA;
    localparam logic [10:0] FAA = 11'h354;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       character_valid = 1'b0;
    logic [7:0] character_byte = 8'h00;
    logic       character_ready;
    logic       uart_tx;
    logic       busy;

    int         n_checks = 0;
    int         n_fail = 0;
    logic       mon_en = 1'b0;
    logic [7:0] rx_q[$];

    always #5 clk = ~clk;

    keyboard_uart_tx #(
        .CLOCK_DIVISOR   (CD),
        .FIFO_DEPTH_LOG2 (2)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .character_ready (character_ready),
        .character_valid (character_valid),
        .character_byte  (character_byte),
        .uart_tx         (uart_tx),
        .busy            (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Serial decoder: samples each bit one cycle into its 4-cycle window.
    initial begin : monitor
        logic [10:0] bits;
        logic [7:0]  d;
        logic        ok;
        bits = 11'h000;
        forever begin
            @(negedge clk);
            if (mon_en && !reset && (uart_tx == 1'b0)) begin
                ok = 1'b1;
                for (int c = 0; c < CD * FB; c++) begin
                    if (c != 0) @(negedge clk);
                    if (!mon_en || reset) begin
                        ok = 1'b0;
                        break;
                    end
                    if ((c % CD) == 1) bits[c / CD] = uart_tx;
                end
                if (ok) begin
                    d = bits[8:1];
                    check("rx_start", 32'(bits[0]), 32'd0);
                    check("rx_stop", 32'(bits[FB - 1]), 32'd1);
`ifdef KEYBOARD_UART_TX_PARITY_EN
                    check("rx_parity", 32'(bits[9]), 32'(^d));
`endif
                    rx_q.push_back(d);
                end
            end
        end
    end

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && (n < 2000)) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_idle"}, 32'(busy), 32'd0);
        repeat (2 * CD) @(negedge clk);
    endtask

    task automatic check_rx(input string tag, input logic [7:0] exp_bytes[$]);
        check({tag, "_rx_count"}, 32'(rx_q.size()), 32'(exp_bytes.size()));
        for (int i = 0; i < exp_bytes.size(); i++) begin
            if (i < rx_q.size()) check($sformatf("%s_rx%0d", tag, i), 32'(rx_q[i]), 32'(exp_bytes[i]));
        end
        rx_q.delete();
    endtask

    task automatic send_single(input logic [7:0] d, input logic [10:0] frame);
        logic [10:0] f;
        logic [7:0]  e[$];
        f = frame;
        @(negedge clk);
        character_valid = 1'b1;
        character_byte  = d;
        @(negedge clk);
        character_valid = 1'b0;
        check("single_busy_rise", 32'(busy), 32'd1);
        @(negedge clk);
        check("single_tx_lag", 32'(uart_tx), 32'd1);
        for (int i = 0; i < CD * FB; i++) begin
            @(negedge clk);
            check($sformatf("frame_%02h_bit%0d", d, i / CD), 32'(uart_tx), 32'(f[i / CD]));
            if (i == CD * FB - 2) check("single_busy_hold", 32'(busy), 32'd1);
            if (i == CD * FB - 1) check("single_busy_fall", 32'(busy), 32'd0);
        end
        wait_idle("single");
        e.push_back(d);
        check_rx("single", e);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [7:0]  seq[20];
        logic [7:0]  sq[$];
        logic [10:0] f;
        int          acc_k[20];
        int          idx;
        int          k;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(character_ready), 32'd0);
        check("rst_tx", 32'(uart_tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_release", 32'(character_ready), 32'd1);
        mon_en = 1'b1;

        // Single bytes
        send_single(8'h41, F41);
        send_single(8'h43, F43);

        // Back-to-back 0x55 then 0xAA
        @(negedge clk);
        character_valid = 1'b1;
        character_byte  = 8'h55;
        @(negedge clk);
        character_byte  = 8'hAA;
        @(negedge clk);
        character_valid = 1'b0;
        for (int i = 0; i < 2 * CD * FB; i++) begin
            f = (i < CD * FB) ? F55 : FAA;
            @(negedge clk);
            check($sformatf("b2b_bit%0d", i / CD), 32'(uart_tx), 32'(f[(i / CD) % FB]));
        end
        wait_idle("b2b");
        sq = {8'h55, 8'hAA};
        check_rx("b2b", sq);

        // Overflow: valid held high with 20 distinct bytes
        for (int i = 0; i < 20; i++) seq[i] = 8'(32 + 7 * i);
        idx = 0;
        k = 0;
        while ((idx < 20) && (k < 3000)) begin
            @(negedge clk);
            character_valid = 1'b1;
            character_byte  = seq[idx];
            if (k == 5) check("ovf_ready_low", 32'(character_ready), 32'd0);
            if (character_ready) begin
                acc_k[idx] = k;
                idx++;
            end
            k++;
        end
        @(negedge clk);
        character_valid = 1'b0;
        check("ovf_accepted", 32'(idx), 32'd20);
        for (int j = 0; j < idx; j++) begin
            check($sformatf("ovf_accept_cycle%0d", j), 32'(acc_k[j]),
                  (j < 5) ? 32'(j) : 32'(2 + (j - 4) * CD * FB));
        end
        wait_idle("ovf");
        sq.delete();
        for (int i = 0; i < 20; i++) sq.push_back(seq[i]);
        check_rx("ovf", sq);

        // Reset during data bit 3 with two bytes queued
        @(negedge clk);
        character_valid = 1'b1;
        character_byte  = 8'h11;
        @(negedge clk);
        character_byte  = 8'h22;
        @(negedge clk);
        character_byte  = 8'h33;
        @(negedge clk);
        character_valid = 1'b0;
        repeat (17) @(negedge clk);
        check("pre_reset_bit3", 32'(uart_tx), 32'd0);
        @(posedge clk);
        mon_en = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        check("midrst_tx", 32'(uart_tx), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_ready", 32'(character_ready), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("post_reset_line", 32'(uart_tx), 32'd1);
        end
        check("post_reset_busy", 32'(busy), 32'd0);
        rx_q.delete();
        mon_en = 1'b1;
        send_single(8'h41, F41);

        // Stalled upstream: random valid, byte stable until accepted
        sq.delete();
        for (int i = 0; i < 12; i++) sq.push_back(8'(8'hC0 ^ (13 * i)));
        idx = 0;
        k = 0;
        while ((idx < 12) && (k < 5000)) begin
            @(negedge clk);
            character_valid = 1'($urandom_range(0, 1));
            character_byte  = sq[idx];
            if (character_valid && character_ready) idx++;
            k++;
        end
        @(negedge clk);
        character_valid = 1'b0;
        check("stall_accepted", 32'(idx), 32'd12);
        wait_idle("stall");
        check_rx("stall", sq);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
